stop_watch_tick_gen: RTL

//  Parametrised multi-rate timebase for the stop-watch datapath. A prescaler

---
 rtl/stop_watch_tick_gen.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/stop_watch_tick_gen.sv
// Multi-rate timebase: prescaler to BASE_HZ, then NUM_STAGES cascaded /DIV stages.
// Every rate has a registered 1-clk strobe (tick) and a ~50% duty square (sq).
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous reset, active low
//   en    - 1 = run, 0 = pause (counters and sq hold, tick low)
//   sclr  - synchronous clear of counters and outputs, wins over en
//   tick  - tick[k] strobes for one clk at BASE_HZ/DIV**k
//   sq    - sq[k] square wave at the rate of tick[k]
//
// Build option: define TICK_GEN_FRAC_ACC_EN to replace the integer prescaler
// with a phase accumulator whose average stage-0 rate is exactly BASE_HZ.

module stop_watch_tick_gen #(
    parameter int CLK_HZ     = 125_000_000,
    parameter int BASE_HZ    = 1_000_000,
    parameter int DIV        = 10,
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sclr,
    output logic [NUM_STAGES:0]   tick,
    output logic [NUM_STAGES:0]   sq
);

    localparam int PRE_DIV = CLK_HZ / BASE_HZ;
    localparam int DW      = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);

`ifdef TICK_GEN_FRAC_ACC_EN
    localparam bit BAD_PRE = (BASE_HZ * 2 > CLK_HZ);
`else
    localparam bit BAD_PRE = (PRE_DIV < 2);
`endif

    generate
        if (BAD_PRE || DIV < 2 || NUM_STAGES < 1) begin : g_bad_cfg
            $error("stop_watch_tick_gen: invalid divider configuration");
        end
    endgenerate

    // w[k] is the wrap of rate k this cycle; it becomes tick[k] next cycle.
    logic [NUM_STAGES:0] w;
    logic                sq0_n;

    logic [DW-1:0] st_q [1:NUM_STAGES];
    logic [DW-1:0] st_d [1:NUM_STAGES];

    logic [NUM_STAGES:0] tick_q, tick_d;
    logic [NUM_STAGES:0] sq_q, sq_d;

`ifdef TICK_GEN_FRAC_ACC_EN
    localparam int AW  = $clog2(CLK_HZ) + 1;
    localparam int AXW = AW + 1;

    localparam logic [AXW-1:0] BASE_X = AXW'(BASE_HZ);
    localparam logic [AXW-1:0] CLK_X  = AXW'(CLK_HZ);
    localparam logic [AW-1:0]  HALF_A = AW'(CLK_HZ / 2);

    logic [AW-1:0]  acc_q, acc_d;
    logic [AXW-1:0] acc_sum;
    logic [AXW-1:0] acc_wrap;

    // One extra bit on the sum so the compare against CLK_HZ never overflows.
    always_comb begin
        acc_d    = acc_q;
        acc_sum  = {1'b0, acc_q} + BASE_X;
        acc_wrap = acc_sum - CLK_X;
        w[0]     = 1'b0;
        sq0_n    = (acc_q >= HALF_A);
        if (en) begin
            if (acc_sum >= CLK_X) begin
                acc_d = acc_wrap[AW-1:0];
                w[0]  = 1'b1;
            end else begin
                acc_d = acc_sum[AW-1:0];
            end
        end
        if (sclr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    localparam int PW = (PRE_DIV > 2) ? $clog2(PRE_DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(PRE_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(PRE_DIV / 2);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        w[0]      = 1'b0;
        sq0_n     = (pre_cnt_q >= PRE_HALF);
        if (en) begin
            if (pre_cnt_q == PRE_MAX) begin
                pre_cnt_d = '0;
                w[0]      = 1'b1;
            end else begin
                pre_cnt_d = pre_cnt_q + PW'(1);
            end
        end
        if (sclr) begin
            pre_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`endif

    // Cascaded stages: each advances only on the wrap of the stage below,
    // so coincident wraps ripple up within the same cycle.
    always_comb begin
        w[NUM_STAGES:1] = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            st_d[k] = st_q[k];
            w[k]    = w[k-1] & (st_q[k] == DIV_MAX);
            if (w[k-1]) begin
                st_d[k] = w[k] ? '0 : st_q[k] + DW'(1);
            end
        end
        if (sclr) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                st_d[k] = '0;
            end
        end
    end

    // sq only samples while running so that a pause freezes it exactly.
    always_comb begin
        tick_d = '0;
        sq_d   = sq_q;
        if (en) begin
            tick_d  = w;
            sq_d[0] = sq0_n;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                sq_d[k] = (st_q[k] >= DIV_HALF);
            end
        end
        if (sclr) begin
            tick_d = '0;
            sq_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                st_q[k] <= '0;
            end
            tick_q <= '0;
            sq_q   <= '0;
        end else begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;

endmodule
